// File: rtl/led_pattern_seq.sv
// led_pattern_seq: tick-driven LED pattern generator (blink, walk, ping-pong, binary count)
module led_pattern_seq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             enable_in,
    input  logic [1:0]       mode_in,
    output logic [WIDTH-1:0] led_out,
    output logic             step_out
);

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [1:0]             mode_q;
    logic [1:0]             mode_d;
    dir_t                   dir_q;
    dir_t                   dir_d;
    logic [WIDTH-1:0]       led_d;
    logic [WIDTH-1:0]       shl;
    logic [WIDTH-1:0]       shr;
    logic [WIDTH-1:0]       rol;
    logic                   sync_last;
    logic                   step;
    logic                   at_end;
    logic                   go_left;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign step      = sync_last & ~hist_q & enable_in;
    assign shl       = {led_out[WIDTH-2:0], 1'b0};
    assign shr       = {1'b0, led_out[WIDTH-1:1]};
    assign rol       = {led_out[WIDTH-2:0], led_out[WIDTH-1]};
    assign at_end    = (dir_q == LEFT) ? led_out[WIDTH-1] : led_out[0];
    assign go_left   = (dir_q == LEFT) ^ at_end;

    // Synchronizer and history keep running regardless of enable so stale edges are dropped
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q <= sync_last;
        end
    end

    // Pattern state and step pulse register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            led_out  <= '0;
            step_out <= 1'b0;
            mode_q   <= 2'd0;
            dir_q    <= LEFT;
        end else begin
            led_out  <= led_d;
            step_out <= step;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
        end
    end

    // Next pattern: a mode change only reseeds; otherwise advance the current pattern
    always_comb begin
        led_d  = led_out;
        mode_d = mode_q;
        dir_d  = dir_q;
        if (step) begin
            if (mode_in != mode_q) begin
                mode_d = mode_in;
                dir_d  = LEFT;
                led_d  = (mode_in == 2'd1 || mode_in == 2'd2) ? ONE : '0;
            end else begin
                unique case (mode_q)
                    2'd0: led_d = ~led_out;
                    2'd1: led_d = (led_out == '0) ? ONE : rol;
                    2'd2: begin
                        led_d = (led_out == '0) ? ONE : (go_left ? shl : shr);
                        dir_d = (led_out == '0) ? dir_q : (go_left ? LEFT : RIGHT);
                    end
                    default: led_d = led_out + ONE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed checks of led_pattern_seq patterns, latency, enable and reset
module tb_led_pattern_seq;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       enable_in;
    logic [1:0] mode_in;
    logic [7:0] led_out;
    logic       step_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int steps  = 0;
    int s0;

    logic [7:0] walk_exp [9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] pong_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    led_pattern_seq #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .enable_in (enable_in),
        .mode_in   (mode_in),
        .led_out   (led_out),
        .step_out  (step_out)
    );

    always #5 clk_in = ~clk_in;

    // Count step pulses away from the active edge
    always @(negedge clk_in) if (step_out) steps++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in) tick_in = 1'b1;
        repeat (4) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b0; enable_in = 1'b1; mode_in = 2'd1;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_step", 32'(step_out), 32'h0);
        @(negedge clk_in) rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            s0 = steps;
            tick();
            check("walk_led", 32'(led_out), 32'(walk_exp[i]));
            check("walk_steps", 32'(steps - s0), 32'd1);
        end

        mode_in = 2'd2;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("pong_led", 32'(led_out), 32'(pong_exp[i]));
        end

        s0 = steps;
        @(negedge clk_in) tick_in = 1'b1;
        @(posedge clk_in) #1 check("lat_n_step", 32'(step_out), 32'h0);
        @(posedge clk_in) #1 check("lat_n1_step", 32'(step_out), 32'h0);
        check("lat_n1_led", 32'(led_out), 32'h02);
        @(posedge clk_in) #1 check("lat_n2_step", 32'(step_out), 32'h1);
        check("lat_n2_led", 32'(led_out), 32'h04);
        @(posedge clk_in) #1 check("lat_n3_step", 32'(step_out), 32'h0);
        repeat (46) @(posedge clk_in);
        @(negedge clk_in) tick_in = 1'b0;
        repeat (6) @(negedge clk_in);
        check("hold_steps", 32'(steps - s0), 32'd1);
        check("hold_led", 32'(led_out), 32'h04);

        s0 = steps;
        enable_in = 1'b0;
        repeat (3) tick();
        check("dis_led", 32'(led_out), 32'h04);
        check("dis_steps", 32'(steps - s0), 32'd0);
        enable_in = 1'b1;
        repeat (10) @(negedge clk_in);
        check("reen_steps", 32'(steps - s0), 32'd0);
        tick();
        check("reen_led", 32'(led_out), 32'h08);
        check("reen_steps2", 32'(steps - s0), 32'd1);

        mode_in = 2'd1;
        repeat (4) tick();
        check("m1_led", 32'(led_out), 32'h08);
        mode_in = 2'd3;
        tick();
        check("m3_seed", 32'(led_out), 32'h00);
        tick();
        check("m3_first", 32'(led_out), 32'h01);
        repeat (253) tick();
        check("cnt_fe", 32'(led_out), 32'hFE);
        tick();
        check("cnt_ff", 32'(led_out), 32'hFF);
        tick();
        check("cnt_wrap", 32'(led_out), 32'h00);

        mode_in = 2'd0;
        tick();
        check("blink_seed", 32'(led_out), 32'h00);
        tick();
        check("blink_on", 32'(led_out), 32'hFF);
        tick();
        check("blink_off", 32'(led_out), 32'h00);
        tick();
        check("blink_on2", 32'(led_out), 32'hFF);

        @(posedge clk_in) #3 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led_out), 32'h0);
        check("async_rst_step", 32'(step_out), 32'h0);

        mode_in = 2'd1;
        tick_in = 1'b1;
        repeat (3) @(negedge clk_in);
        s0 = steps;
        rst_n = 1'b1;
        repeat (6) @(negedge clk_in);
        check("rel_high_led", 32'(led_out), 32'h01);
        check("rel_high_steps", 32'(steps - s0), 32'd1);
        tick_in = 1'b0;
        repeat (4) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
